// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
// Purpose : bundles the two writeback requesters, the register-file write
//           port and the status/statistics outputs of rf_write_arbiter.
// Modports: master - requester side (drives valid/rd/data, observes the rest)
//           slave  - arbiter side
// Signals : a_valid/a_ready/a_rd/a_data   requester A (ALU writeback)
//           b_valid/b_ready/b_rd/b_data   requester B (memory load)
//           RFwenable/RFrd/RFwr           registered RF write port
//           a_pending/b_pending           holding entry occupied
//           wr_count/conflict_count       statistics (zero unless RFWA_STATS_EN)
interface rf_write_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        RFwenable;
    logic [4:0]  RFrd;
    logic [31:0] RFwr;
    logic        a_pending;
    logic        b_pending;
    logic [15:0] wr_count;
    logic [15:0] conflict_count;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, RFwenable, RFrd, RFwr,
               a_pending, b_pending, wr_count, conflict_count
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, RFwenable, RFrd, RFwr,
               a_pending, b_pending, wr_count, conflict_count
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Purpose : arbitrates two writeback requesters onto one registered
//           register-file write port. Each requester owns a one-entry
//           holding register; when both are full, different destinations
//           alternate round-robin and the same destination is served in
//           load order so the younger value lands last.
// Ports   : clk    - single clock, all state on posedge
//           rst_n  - asynchronous active-low reset
//           bus    - rf_write_arbiter_if.slave (requesters, RF port, status)
// Config  : RFWA_STATS_EN - when defined, wr_count/conflict_count are
//           saturating 16-bit counters; otherwise both are tied to zero.
module rf_write_arbiter (
    input  logic                clk,
    input  logic                rst_n,
    rf_write_arbiter_if.slave   bus
);

    logic        a_full_q, a_full_d;
    logic [4:0]  a_rd_q, a_rd_d;
    logic [31:0] a_data_q, a_data_d;
    logic        b_full_q, b_full_d;
    logic [4:0]  b_rd_q, b_rd_d;
    logic [31:0] b_data_q, b_data_d;
    logic        last_grant_q, last_grant_d;   // 1 = B was granted last
    logic        age_q, age_d;                 // 1 = B loaded before A
    logic        rf_wen_q, rf_wen_d;
    logic [4:0]  rf_rd_q, rf_rd_d;
    logic [31:0] rf_wr_q, rf_wr_d;

    logic grant_a, grant_b;
    logic a_xfer, b_xfer;
    logic a_ready, b_ready;
    logic a_old, b_old;

    always_comb begin
        grant_a = a_full_q;
        if (a_full_q && b_full_q) begin
            if (a_rd_q == b_rd_q) grant_a = !age_q;
            else                  grant_a = last_grant_q;
        end
        grant_b = b_full_q && !grant_a;
    end

    // An entry being drained this edge can accept a new request at once.
    assign a_ready = !a_full_q || grant_a;
    assign b_ready = !b_full_q || grant_b;
    assign a_xfer  = bus.a_valid && a_ready;
    assign b_xfer  = bus.b_valid && b_ready;

    // Entries that survive this edge without being replaced.
    assign a_old = a_full_q && !grant_a;
    assign b_old = b_full_q && !grant_b;

    always_comb begin
        a_full_d     = a_xfer || a_old;
        a_rd_d       = a_xfer ? bus.a_rd   : a_rd_q;
        a_data_d     = a_xfer ? bus.a_data : a_data_q;
        b_full_d     = b_xfer || b_old;
        b_rd_d       = b_xfer ? bus.b_rd   : b_rd_q;
        b_data_d     = b_xfer ? bus.b_data : b_data_q;

        // Age only matters while both are full; same-edge loads count A older.
        age_d = 1'b0;
        if (a_full_d && b_full_d) begin
            if (a_old && b_old) age_d = age_q;
            else if (b_old)     age_d = 1'b1;
            else                age_d = 1'b0;
        end

        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wr_d      = rf_wr_q;
        if (grant_a) begin
            last_grant_d = 1'b0;
            rf_wen_d     = (a_rd_q != 5'd0);
            rf_rd_d      = a_rd_q;
            rf_wr_d      = a_data_q;
        end else if (grant_b) begin
            last_grant_d = 1'b1;
            rf_wen_d     = (b_rd_q != 5'd0);
            rf_rd_d      = b_rd_q;
            rf_wr_d      = b_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full_q     <= 1'b0;
            a_rd_q       <= 5'd0;
            a_data_q     <= 32'd0;
            b_full_q     <= 1'b0;
            b_rd_q       <= 5'd0;
            b_data_q     <= 32'd0;
            last_grant_q <= 1'b1;
            age_q        <= 1'b0;
            rf_wen_q     <= 1'b0;
            rf_rd_q      <= 5'd0;
            rf_wr_q      <= 32'd0;
        end else begin
            a_full_q     <= a_full_d;
            a_rd_q       <= a_rd_d;
            a_data_q     <= a_data_d;
            b_full_q     <= b_full_d;
            b_rd_q       <= b_rd_d;
            b_data_q     <= b_data_d;
            last_grant_q <= last_grant_d;
            age_q        <= age_d;
            rf_wen_q     <= rf_wen_d;
            rf_rd_q      <= rf_rd_d;
            rf_wr_q      <= rf_wr_d;
        end
    end

`ifdef RFWA_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] conflict_count_q, conflict_count_d;

    always_comb begin
        wr_count_d       = wr_count_q;
        conflict_count_d = conflict_count_q;
        if (rf_wen_q && (wr_count_q != 16'hFFFF))
            wr_count_d = wr_count_q + 16'd1;
        if (a_full_q && b_full_q && (conflict_count_q != 16'hFFFF))
            conflict_count_d = conflict_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q       <= 16'd0;
            conflict_count_q <= 16'd0;
        end else begin
            wr_count_q       <= wr_count_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign bus.wr_count       = wr_count_q;
    assign bus.conflict_count = conflict_count_q;
`else
    assign bus.wr_count       = 16'd0;
    assign bus.conflict_count = 16'd0;
`endif

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.a_pending = a_full_q;
    assign bus.b_pending = b_full_q;
    assign bus.RFwenable = rf_wen_q;
    assign bus.RFrd      = rf_rd_q;
    assign bus.RFwr      = rf_wr_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic clk;
    logic rst_n;
    rf_write_arbiter_if bus();

    rf_write_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] rf_model [32];
    always @(negedge clk) begin
        if (bus.RFwenable) rf_model[bus.RFrd] <= bus.RFwr;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        ear;   // a_ready before the edge
        logic        ebr;   // b_ready before the edge
        logic        ewen;  // outputs after the edge
        logic [4:0]  erd;
        logic [31:0] ewr;
        logic        eap;
        logic        ebp;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        bus.a_valid = av;
        bus.a_rd    = ard;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_rd    = brd;
        bus.b_data  = bd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // lone A stream
        tbl[0]  = '{1'b1, 5'd3, 32'd10, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h0000BBBB, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 5'd4, 32'd11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd10, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 5'd5, 32'd12, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd4, 32'd11, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 5'd6, 32'd13, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'd12, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd6, 32'd13, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd6, 32'd13, 1'b0, 1'b0};
        // contention, different rd, last grant was A -> B first
        tbl[6]  = '{1'b1, 5'd1, 32'h0000AAAA, 1'b1, 5'd2, 32'h0000BBBB, 1'b1, 1'b1, 1'b0, 5'd6, 32'd13, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000BBBB, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h0000AAAA, 1'b0, 1'b0};
        // same rd loaded on same edge, last grant A -> age wins, A first
        tbl[9]  = '{1'b1, 5'd8, 32'h111, 1'b1, 5'd8, 32'h222, 1'b1, 1'b1, 1'b0, 5'd1, 32'h0000AAAA, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h111, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h222, 1'b0, 1'b0};
        // x0 drop
        tbl[12] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h222, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
        // same rd, B then A one edge later
        tbl[15] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 5'd7, 32'd9, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'd5, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'd9, 1'b0, 1'b0};
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("reset a_pending", {31'd0, bus.a_pending}, 32'd0);
        chk("reset b_pending", {31'd0, bus.b_pending}, 32'd0);
        chk("reset RFwenable", {31'd0, bus.RFwenable}, 32'd0);
        chk("reset RFrd", {27'd0, bus.RFrd}, 32'd0);
        chk("reset RFwr", bus.RFwr, 32'd0);
        chk("reset a_ready", {31'd0, bus.a_ready}, 32'd1);
        chk("reset b_ready", {31'd0, bus.b_ready}, 32'd1);
        do_reset();

        // contention right after reset: A first, then B
        drive(1'b1, 5'd1, 32'h0000AAAA, 1'b1, 5'd2, 32'h0000BBBB);
        cyc();
        idle();
        chk("ctn e0 a_pending", {31'd0, bus.a_pending}, 32'd1);
        chk("ctn e0 b_pending", {31'd0, bus.b_pending}, 32'd1);
        chk("ctn e0 RFwenable", {31'd0, bus.RFwenable}, 32'd0);
        cyc();
        chk("ctn e1 RFwenable", {31'd0, bus.RFwenable}, 32'd1);
        chk("ctn e1 RFrd", {27'd0, bus.RFrd}, 32'd1);
        chk("ctn e1 RFwr", bus.RFwr, 32'h0000AAAA);
        cyc();
        chk("ctn e2 RFwenable", {31'd0, bus.RFwenable}, 32'd1);
        chk("ctn e2 RFrd", {27'd0, bus.RFrd}, 32'd2);
        chk("ctn e2 RFwr", bus.RFwr, 32'h0000BBBB);
        cyc();
        chk("ctn e3 RFwenable", {31'd0, bus.RFwenable}, 32'd0);
`ifdef RFWA_STATS_EN
        chk("ctn conflict_count", {16'd0, bus.conflict_count}, 32'd1);
        chk("ctn wr_count", {16'd0, bus.wr_count}, 32'd2);
`endif

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].bv, tbl[i].brd, tbl[i].bd);
            #1;
            chk($sformatf("v%0d a_ready", i), {31'd0, bus.a_ready}, {31'd0, tbl[i].ear});
            chk($sformatf("v%0d b_ready", i), {31'd0, bus.b_ready}, {31'd0, tbl[i].ebr});
            cyc();
            chk($sformatf("v%0d RFwenable", i), {31'd0, bus.RFwenable}, {31'd0, tbl[i].ewen});
            chk($sformatf("v%0d RFrd", i), {27'd0, bus.RFrd}, {27'd0, tbl[i].erd});
            chk($sformatf("v%0d RFwr", i), bus.RFwr, tbl[i].ewr);
            chk($sformatf("v%0d a_pending", i), {31'd0, bus.a_pending}, {31'd0, tbl[i].eap});
            chk($sformatf("v%0d b_pending", i), {31'd0, bus.b_pending}, {31'd0, tbl[i].ebp});
        end
        idle();
        @(negedge clk);
        #1;
        chk("rf x7 final", rf_model[7], 32'd9);
        chk("rf x8 final", rf_model[8], 32'h222);
        chk("rf x3 final", rf_model[3], 32'd10);

        // reset pulse between edges with both entries held
        #4;
        drive(1'b1, 5'd10, 32'h55, 1'b1, 5'd11, 32'h66);
        cyc();
        idle();
        chk("rmid a_pending before", {31'd0, bus.a_pending}, 32'd1);
        chk("rmid b_pending before", {31'd0, bus.b_pending}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid a_pending", {31'd0, bus.a_pending}, 32'd0);
        chk("rmid b_pending", {31'd0, bus.b_pending}, 32'd0);
        chk("rmid RFwenable", {31'd0, bus.RFwenable}, 32'd0);
        chk("rmid a_ready", {31'd0, bus.a_ready}, 32'd1);
        chk("rmid b_ready", {31'd0, bus.b_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("rmid post%0d RFwenable", k), {31'd0, bus.RFwenable}, 32'd0);
            chk($sformatf("rmid post%0d RFrd", k), {27'd0, bus.RFrd}, 32'd0);
        end
        chk("rmid x10 untouched", rf_model[10], 32'hx);

`ifdef RFWA_STATS_EN
        do_reset();
        drive(1'b1, 5'd1, 32'd1, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 65541; k++) cyc();
        idle();
        cyc();
        cyc();
        chk("sat wr_count", {16'd0, bus.wr_count}, 32'h0000FFFF);
`else
        chk("nostats wr_count", {16'd0, bus.wr_count}, 32'd0);
        chk("nostats conflict_count", {16'd0, bus.conflict_count}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
